// File: rtl/nibbler_pkg.sv
// -----------------------------------------------------------------------------
// nibbler_pkg
// Shared definitions for the Nibbler datapath blocks.
//   ram_state_t : state encoding for the data RAM clear sequencer
//   NIB_DATA_W  : default data word width (4 bits)
//   NIB_ADDR_W  : default data address width (12 bits, 4096 words)
// -----------------------------------------------------------------------------
package nibbler_pkg;

  typedef enum logic [0:0] {
    RAM_CLEAR = 1'b0,
    RAM_IDLE  = 1'b1
  } ram_state_t;

  localparam int unsigned NIB_DATA_W = 4;
  localparam int unsigned NIB_ADDR_W = 12;

endpackage : nibbler_pkg

// File: rtl/ram_clear_seq.sv
// -----------------------------------------------------------------------------
// ram_clear_seq
// Post-reset clear sequencer for ram_sync. After reset is released it walks
// every address once, asking the RAM to write its initial value, then parks
// in RAM_IDLE until the next reset.
// Only built when RAM_CLEAR_EN is defined (see ram_sync).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-low reset
//   clr_we   out  write strobe for the sweep (high while clearing)
//   clr_addr out  address being cleared this cycle
//   busy     out  sweep in progress; registered
// -----------------------------------------------------------------------------
module ram_clear_seq
  import nibbler_pkg::*;
#(
  parameter int unsigned ADDR_W = NIB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == RAM_CLEAR) begin
      // The counter wraps to zero naturally on the last word.
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d = RAM_IDLE;
      end
    end
    busy_d = (state_d == RAM_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RAM_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign clr_we   = (state_q == RAM_CLEAR);
  assign clr_addr = clr_cnt_q;
  assign busy     = busy_q;

endmodule : ram_clear_seq

// File: rtl/ram_sync.sv
// -----------------------------------------------------------------------------
// ram_sync
// Synchronous single-port data RAM for the Nibbler datapath. Separate input
// and output data buses, one-cycle registered read with a read-valid strobe.
//
// Build option RAM_CLEAR_EN:
//   defined   : after reset every word is written with INIT_VAL by a sweep
//               (ram_clear_seq); accesses during the sweep are dropped and
//               flagged on the sticky drop_err.
//   undefined : no sweep, busy and drop_err are tied low, contents after
//               power-up are undefined.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-low reset
//   cs       in   chip select
//   we       in   1 = write, 0 = read (when cs = 1)
//   addr     in   word address
//   din      in   write data
//   dout     out  registered read data, holds the last read value
//   rvalid   out  one-cycle pulse: dout updated by the previous read
//   busy     out  clear sweep in progress
//   drop_err out  sticky: access requested while busy
// -----------------------------------------------------------------------------
module ram_sync
  import nibbler_pkg::*;
#(
  parameter int unsigned       DATA_W   = NIB_DATA_W,
  parameter int unsigned       ADDR_W   = NIB_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              busy,
  output logic              drop_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy_w;

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rvalid_q, rvalid_d;

`ifdef RAM_CLEAR_EN
  logic drop_err_q, drop_err_d;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy_w)
  );

  always_comb begin
    drop_err_d = drop_err_q | (cs & busy_w);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= drop_err_d;
    end
  end

  assign drop_err = drop_err_q;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy_w   = 1'b0;
  assign drop_err = 1'b0;
`endif

  // User accesses are only honoured once the sweep has finished.
  assign accept = cs & ~busy_w;

  // The sweep owns the write port while it runs; user writes cannot collide
  // with it because accept is low during the sweep.
  assign wr_en   = clr_we | (accept & we);
  assign wr_addr = clr_we ? clr_addr : addr;
  assign wr_data = clr_we ? INIT_VAL : din;

  assign rd_data = mem[addr];

  // Reset leaves the array alone; only the registered outputs are cleared.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    if (accept && !we) begin
      dout_d   = rd_data;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_w;

endmodule : ram_sync

// File: tb/tb_ram_sync.sv
// -----------------------------------------------------------------------------
// tb_ram_sync
// Self-checking bench for ram_sync (DATA_W=4, ADDR_W=4, INIT_VAL=4'hA).
// Works with RAM_CLEAR_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_ram_sync;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [3:0]  INIT  = 4'hA;
`ifdef RAM_CLEAR_EN
  localparam int CLR_DEPTH = DEPTH;
`else
  localparam int CLR_DEPTH = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, cs, we;
  logic [3:0] addr, din;
  logic [3:0] dout;
  logic       rvalid, busy, drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array plus expected registered outputs.
  logic [3:0] mem_m [DEPTH];
  logic [3:0] exp_dout;
  logic       exp_rvalid;
  logic       exp_drop;
  int         sweep_left;

  ram_sync #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .INIT_VAL (INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .rvalid   (rvalid),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by one edge, sample at +1.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [3:0] a, input logic [3:0] d);
    reset = r; cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    if (!r) begin
      exp_dout   = '0;
      exp_rvalid = 1'b0;
      exp_drop   = 1'b0;
      sweep_left = CLR_DEPTH;
    end else if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = INIT;
      sweep_left--;
      exp_rvalid = 1'b0;
      if (c) exp_drop = 1'b1;
    end else begin
      exp_rvalid = 1'b0;
      if (c && w) begin
        mem_m[a] = d;
      end else if (c) begin
        exp_dout   = mem_m[a];
        exp_rvalid = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_all();
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("busy", 32'(busy), 32'(sweep_left > 0));
    chk("drop_err", 32'(drop_err), 32'(exp_drop));
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    sweep_left = 0; exp_dout = '0; exp_rvalid = 1'b0; exp_drop = 1'b0;

    // Reset, including a requested read while reset is low.
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd5, 4'd0);
    check_all();
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_busy", 32'(busy), 32'(CLR_DEPTH > 0));
    chk("reset_drop_err", 32'(drop_err), 32'h0);

`ifdef RAM_CLEAR_EN
    // Sweep: busy for 16 edges; a write at sweep cycle 5 is dropped.
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 5) step(1'b1, 1'b1, 1'b1, 4'd2, 4'h7);
      else        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_all();
      chk("sweep_busy", 32'(busy), 32'(k < DEPTH));
    end
    chk("drop_err_set", 32'(drop_err), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'(i), 4'd0);
      check_all();
      chk("sweep_val", 32'(dout), 32'(INIT));
      chk("sweep_rvalid", 32'(rvalid), 32'h1);
    end
`else
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'h9);
    check_all();
    chk("noclr_busy", 32'(busy), 32'h0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    check_all();
    chk("noclr_rd0", 32'(dout), 32'h9);
    chk("noclr_rvalid", 32'(rvalid), 32'h1);
    // Give every word a defined value for the rest of the run.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'(i), 4'($urandom));
      check_all();
    end
`endif

    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all();

    // Directed write/read, then back-to-back reads, then hold.
    step(1'b1, 1'b1, 1'b1, 4'd3, 4'h5);
    check_all();
    step(1'b1, 1'b1, 1'b1, 4'd15, 4'hC);
    check_all();
    chk("wr_rvalid_low", 32'(rvalid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 4'd15, 4'd0);
    check_all();
    chk("rd15", 32'(dout), 32'hC);
    chk("rd15_rvalid", 32'(rvalid), 32'h1);
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'd0);
    check_all();
    chk("rd3", 32'(dout), 32'h5);
    chk("rd3_rvalid", 32'(rvalid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'(k), 4'hF);
      check_all();
      chk("hold_dout", 32'(dout), 32'h5);
      chk("hold_rvalid", 32'(rvalid), 32'h0);
    end
    chk("drop_err_sticky", 32'(drop_err), 32'(CLR_DEPTH > 0));

    // Read-after-write on consecutive cycles.
    step(1'b1, 1'b1, 1'b1, 4'd7, 4'h3);
    check_all();
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd0);
    check_all();
    chk("raw", 32'(dout), 32'h3);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom));
      check_all();
    end

    // Reset in the middle of a read: the pending rvalid is cancelled.
    step(1'b1, 1'b1, 1'b0, 4'd3, 4'd0);
    check_all();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all();
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_drop_err", 32'(drop_err), 32'h0);

`ifdef RAM_CLEAR_EN
    // Reset at sweep cycle 8: the sweep restarts and runs 16 more edges.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_all();
    end
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all();
    chk("resweep_start_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_all();
      chk("resweep_busy", 32'(busy), 32'(k < DEPTH));
      chk("resweep_dout", 32'(dout), 32'h0);
    end
    step(1'b1, 1'b1, 1'b0, 4'd9, 4'd0);
    check_all();
    chk("resweep_val", 32'(dout), 32'(INIT));
`else
    step(1'b1, 1'b1, 1'b0, 4'd15, 4'd0);
    check_all();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_sync
